// File: rtl/xor_stream_descrambler.sv
// Receive-side descrambler: hunts for a sync word, strips an additive LFSR keystream
// from each payload byte and checks the trailing XOR-parity byte of every frame.
module xor_stream_descrambler #(
    parameter int                 DATA_W    = 8,
    parameter int                 LFSR_W    = 7,
    parameter logic [LFSR_W-1:0]  POLY      = 7'h48,
    parameter logic [LFSR_W-1:0]  SEED      = 7'h7F,
    parameter logic [DATA_W-1:0]  SYNC_WORD = 8'hA5,
    parameter int                 FRAME_LEN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              sync_locked,
    output logic              frame_ok,
    output logic              parity_err,
    output logic [7:0]        err_cnt
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                frame_ok_q, frame_ok_d;
    logic                parity_err_q, parity_err_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic [LFSR_W-1:0]   lfsr_next_s;
    logic [DATA_W-1:0]   ks_s;
    logic [DATA_W-1:0]   plain_s;
    logic                accept_s;

    // Eight LFSR steps per byte; the first feedback bit pairs with the byte LSB.
    function automatic logic [LFSR_W+DATA_W-1:0] keystream(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] st;
        logic [DATA_W-1:0] ks;
        logic              fb;
        st = s;
        ks = {DATA_W{1'b0}};
        for (int k = 0; k < DATA_W; k++) begin
            fb    = ^(st & POLY);
            ks[k] = fb;
            st    = {st[LFSR_W-2:0], fb};
        end
        return {st, ks};
    endfunction

    assign {lfsr_next_s, ks_s} = keystream(lfsr_q);
    assign plain_s     = in_data ^ ks_s;
    assign in_ready    = (state_q == ST_PAYLOAD) ? (!out_valid_q || out_ready) : 1'b1;
    assign accept_s    = in_valid && in_ready;
    assign sync_locked = (state_q != ST_HUNT);

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign frame_ok   = frame_ok_q;
    assign parity_err = parity_err_q;
    assign err_cnt    = err_cnt_q;

    // Next-state logic for the framing FSM, output register and parity tracking.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        frame_ok_d   = 1'b0;
        parity_err_d = 1'b0;
        err_cnt_d    = err_cnt_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            ST_HUNT: begin
                if (accept_s && (in_data == SYNC_WORD)) begin
                    lfsr_d  = SEED;
                    cnt_d   = {CNT_W{1'b0}};
                    acc_d   = {DATA_W{1'b0}};
                    state_d = ST_PAYLOAD;
                end else begin
                    state_d = ST_HUNT;
                end
            end
            ST_PAYLOAD: begin
                // Sync-word values here are plain data; no resync mid-frame.
                if (accept_s) begin
                    out_data_d  = plain_s;
                    out_valid_d = 1'b1;
                    out_last_d  = (cnt_q == LAST_IDX);
                    acc_d       = acc_q ^ plain_s;
                    lfsr_d      = lfsr_next_s;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_CHECK: begin
                if (accept_s) begin
                    if (in_data == acc_q) begin
                        frame_ok_d = 1'b1;
                    end else begin
                        parity_err_d = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end else begin
                            err_cnt_d = err_cnt_q;
                        end
                    end
                    state_d = ST_HUNT;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    // State and output registers; reset discards any partial frame silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HUNT;
            lfsr_q       <= SEED;
            cnt_q        <= {CNT_W{1'b0}};
            acc_q        <= {DATA_W{1'b0}};
            out_data_q   <= {DATA_W{1'b0}};
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_ok_q   <= 1'b0;
            parity_err_q <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            frame_ok_q   <= frame_ok_d;
            parity_err_q <= parity_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_xor_stream_descrambler.sv
// Directed bench: instance 0 runs one-byte frames, instance 1 runs sixteen-byte frames.
module tb_xor_stream_descrambler;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0][7:0] in_data;
    logic [1:0]      in_valid;
    logic [1:0]      in_ready;
    logic [1:0][7:0] out_data;
    logic [1:0]      out_valid;
    logic [1:0]      out_ready;
    logic [1:0]      out_last;
    logic [1:0]      sync_locked;
    logic [1:0]      frame_ok;
    logic [1:0]      parity_err;
    logic [1:0][7:0] err_cnt;

    int checks = 0;
    int errors = 0;
    logic [6:0] lfsr_m;
    logic [7:0] acc_m;

    always #5 clk = ~clk;

    xor_stream_descrambler #(.FRAME_LEN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_last(out_last[0]), .sync_locked(sync_locked[0]), .frame_ok(frame_ok[0]),
        .parity_err(parity_err[0]), .err_cnt(err_cnt[0])
    );

    xor_stream_descrambler #(.FRAME_LEN(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_last(out_last[1]), .sync_locked(sync_locked[1]), .frame_ok(frame_ok[1]),
        .parity_err(parity_err[1]), .err_cnt(err_cnt[1])
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference keystream: taps 6 and 3 of the 7-bit register, LSB of the byte first.
    task automatic next_ks(output logic [7:0] ks);
        logic fb;
        for (int k = 0; k < 8; k++) begin
            fb     = lfsr_m[6] ^ lfsr_m[3];
            ks[k]  = fb;
            lfsr_m = {lfsr_m[5:0], fb};
        end
    endtask

    task automatic push(input int d, input logic [7:0] b);
        int n;
        n = 0;
        in_data[d]  = b;
        in_valid[d] = 1'b1;
        #1;
        while (!in_ready[d] && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 50) check_val("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic push_payload(input int d, input logic [7:0] raw, input logic exp_last);
        logic [7:0] ks;
        logic [7:0] exp;
        next_ks(ks);
        exp = raw ^ ks;
        push(d, raw);
        check_val("pl_valid", 32'(out_valid[d]), 32'd1);
        check_val("pl_data", 32'(out_data[d]), 32'(exp));
        check_val("pl_last", 32'(out_last[d]), 32'(exp_last));
        acc_m = acc_m ^ exp;
    endtask

    initial begin
        logic [7:0] raw;
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 2'b00;
        out_ready = 2'b11;
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            check_val("rst_out_valid", 32'(out_valid[d]), 32'd0);
            check_val("rst_out_data", 32'(out_data[d]), 32'd0);
            check_val("rst_err_cnt", 32'(err_cnt[d]), 32'd0);
            check_val("rst_sync", 32'(sync_locked[d]), 32'd0);
            check_val("rst_pulses", 32'({frame_ok[d], parity_err[d], out_last[d]}), 32'd0);
        end
        rst_n = 1'b1;
        tick();

        // One-byte frame, good parity
        push(0, 8'hA5);
        check_val("t1_sync", 32'(sync_locked[0]), 32'd1);
        check_val("t1_no_sync_fwd", 32'(out_valid[0]), 32'd0);
        lfsr_m = 7'h7F; acc_m = 8'h00;
        push_payload(0, 8'h70, 1'b1);
        check_val("t1_data_hand", 32'(out_data[0]), 32'h00);
        push(0, 8'h00);
        check_val("t1_frame_ok", 32'(frame_ok[0]), 32'd1);
        check_val("t1_no_perr", 32'(parity_err[0]), 32'd0);
        check_val("t1_err_cnt", 32'(err_cnt[0]), 32'd0);
        check_val("t1_unlock", 32'(sync_locked[0]), 32'd0);
        tick();
        check_val("t1_ok_pulse_end", 32'(frame_ok[0]), 32'd0);

        // One-byte frame, bad parity
        push(0, 8'hA5);
        push(0, 8'h70);
        check_val("t2_data", 32'(out_data[0]), 32'h00);
        check_val("t2_locked_check", 32'(sync_locked[0]), 32'd1);
        push(0, 8'hFF);
        check_val("t2_perr", 32'(parity_err[0]), 32'd1);
        check_val("t2_no_ok", 32'(frame_ok[0]), 32'd0);
        check_val("t2_err_cnt", 32'(err_cnt[0]), 32'd1);
        check_val("t2_unlock", 32'(sync_locked[0]), 32'd0);
        tick();
        check_val("t2_perr_pulse_end", 32'(parity_err[0]), 32'd0);

        // Hunt through junk, then a sixteen-byte frame with a consumer stall
        push(1, 8'h12);
        check_val("t3_drop12", 32'({out_valid[1], sync_locked[1]}), 32'd0);
        push(1, 8'h34);
        check_val("t3_drop34", 32'({out_valid[1], sync_locked[1]}), 32'd0);
        push(1, 8'hA5);
        check_val("t3_sync_nofwd", 32'(out_valid[1]), 32'd0);
        check_val("t3_locked", 32'(sync_locked[1]), 32'd1);
        lfsr_m = 7'h7F; acc_m = 8'h00;
        push_payload(1, 8'h70, 1'b0);
        check_val("t3_first_hand", 32'(out_data[1]), 32'h00);

        out_ready[1] = 1'b0;
        in_data[1]   = 8'h5D;
        in_valid[1]  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check_val("t4_stall_ready", 32'(in_ready[1]), 32'd0);
            check_val("t4_stall_data", 32'(out_data[1]), 32'h00);
            check_val("t4_stall_valid", 32'(out_valid[1]), 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready[1] = 1'b1;
        push_payload(1, 8'h5D, 1'b0);
        for (int i = 2; i < 16; i++) begin
            raw = (i == 5) ? 8'hA5 : ((8'(i) * 8'h1D) ^ 8'h5C);
            push_payload(1, raw, (i == 15));
        end
        check_val("t4_locked_check", 32'(sync_locked[1]), 32'd1);
        push(1, acc_m);
        check_val("t4_frame_ok", 32'(frame_ok[1]), 32'd1);
        check_val("t4_no_perr", 32'(parity_err[1]), 32'd0);

        // Reset mid-frame after the third payload byte
        push(1, 8'hA5);
        lfsr_m = 7'h7F; acc_m = 8'h00;
        push_payload(1, 8'h70, 1'b0);
        push_payload(1, 8'h11, 1'b0);
        push_payload(1, 8'h22, 1'b0);
        rst_n = 1'b0;
        #1;
        check_val("t5_valid_clr", 32'(out_valid[1]), 32'd0);
        check_val("t5_data_clr", 32'(out_data[1]), 32'd0);
        check_val("t5_unlock", 32'(sync_locked[1]), 32'd0);
        check_val("t5_err_cnt0_clr", 32'(err_cnt[0]), 32'd0);
        check_val("t5_no_pulse", 32'({frame_ok[1], parity_err[1]}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        push(1, 8'hA5);
        lfsr_m = 7'h7F; acc_m = 8'h00;
        push_payload(1, 8'h70, 1'b0);
        check_val("t5_first_hand", 32'(out_data[1]), 32'h00);

        // Error counter saturation over 257 bad frames
        for (int f = 0; f < 257; f++) begin
            push(0, 8'hA5);
            push(0, 8'h70);
            push(0, 8'hFF);
            check_val("t6_perr", 32'(parity_err[0]), 32'd1);
            check_val("t6_err_cnt", 32'(err_cnt[0]), (f + 1 > 255) ? 32'd255 : 32'(f + 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xor_stream_descrambler.md
Name: xor_stream_descrambler

Overview:
Receive-side counterpart of the team's XOR scrambler and parity generator.
- Hunts a byte stream for a sync word, then descrambles each payload byte by XOR with an additive LFSR keystream.
- Checks the trailing XOR-parity byte of each frame.
- Sits between the byte deserializer and the frame consumer, with valid/ready handshakes on both sides.

Parameters:
DATA_W, 8, byte width; fixed at 8, since keystream generation steps 8 LFSR bits per byte
LFSR_W, 7, LFSR state width
POLY, 7'h48, tap mask; feedback fb = ^(state & POLY)
SEED, 7'h7F, LFSR value loaded on every sync detect and at reset
SYNC_WORD, 8'hA5, frame sync marker; never forwarded
FRAME_LEN, 16, payload bytes per frame (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_data  in  8  scrambled byte from deserializer
in_valid  in  1  in_data valid
in_ready  out  1  block accepts in_data this cycle
out_data  out  8  descrambled payload byte
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts out_data
out_last  out  1  marks the final payload byte of the frame
sync_locked  out  1  high while the FSM is not in HUNT
frame_ok  out  1  one-cycle pulse: parity matched
parity_err  out  1  one-cycle pulse: parity mismatched
err_cnt  out  8  saturating parity-error count

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State = HUNT, LFSR = SEED, byte counter = 0, parity accumulator = 0.
  - All outputs are 0: out_data, out_valid, out_last, frame_ok, parity_err, err_cnt, sync_locked.
  - Reset mid-frame discards the frame; no pulses are emitted.
- Acceptance: a byte is accepted when in_valid && in_ready are both high at a clk edge.
- Keystream, per accepted payload byte, for k=0..7:
  - ks[k] = fb;
  - state <= {state[5:0], fb}.
  - All 8 steps complete within one cycle.
  - Output byte = in_data ^ ks. ks[0] pairs with in_data[0] (LSB first).
- FSM HUNT:
  - in_ready=1.
  - Accepted bytes are dropped.
  - If the byte equals SYNC_WORD: load LFSR=SEED, clear counter and accumulator, go to PAYLOAD.
- FSM PAYLOAD:
  - in_ready = !out_valid || out_ready.
  - On accept: register out_data = in_data^ks and set out_valid=1. Latency is 1 cycle.
  - Update accumulator ^= out_data and increment the counter.
  - out_last = 1 when the counter is FRAME_LEN-1; after that byte, go to CHECK.
  - A SYNC_WORD value inside the payload is treated as data; there is no resync.
- FSM CHECK:
  - in_ready=1.
  - The next accepted byte is the raw (unscrambled) parity byte; it is not forwarded.
  - Equal to the accumulator: frame_ok=1 for one cycle.
  - Mismatch: parity_err=1 for one cycle and err_cnt += 1, saturating at 255.
  - Then go to HUNT.
- Output register:
  - Cleared (out_valid=0) on out_valid && out_ready when no new byte is accepted in the same cycle.
  - With simultaneous pop and accept, the register is overwritten and out_valid stays 1.
  - out_data and out_last stay stable while out_valid && !out_ready.
- Pulse ordering: frame_ok/parity_err may assert while the last payload byte is still held in the output register. This ordering is legal.
- sync_locked is combinational from state: it is 1 in PAYLOAD and CHECK.
- in_valid=0 stalls all state; the LFSR advances only on accepted payload bytes.

Test Plan:
1. FRAME_LEN=1, inputs A5, 70, 00 -> out_data=00 with out_last=1 one cycle after the 70 is accepted; frame_ok pulses once; err_cnt=0.
2. FRAME_LEN=1, inputs A5, 70, FF -> out_data=00; parity_err pulses once; err_cnt=1; sync_locked returns to 0.
3. HUNT: inputs 12, 34, A5, 70, … -> no out_valid for 12/34/A5; first output is 00; sync_locked rises after A5 is accepted.
4. FRAME_LEN=16, out_ready held 0 for 5 cycles after the first output -> in_ready=0; out_data stays 00; no byte is lost; the remaining 15 bytes match the reference model's keystream.
5. rst_n pulsed low after payload byte 3 of 16 -> outputs clear immediately; the next frame starting with A5 decodes its first byte 70 as 00.
6. 257 consecutive bad-parity frames -> err_cnt holds 255; a parity_err pulse occurs for every frame.
